// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// Purpose:
//   Sums a stream of signed products from an upstream multiplier into one
//   signed accumulator per vector. A vector closes on a term flagged with
//   last_i or when the term count reaches MAX_TERMS. The result is then held
//   until downstream takes it. A new vector's first term can be accepted in
//   the same cycle that the previous result is consumed.
//
// Configuration macro:
//   ACC_SAT_EN - when defined, an overflowing sum clamps to the most positive
//                or most negative ACC_W-bit value. When undefined, the sum
//                wraps modulo 2^ACC_W. In both builds ovf_o flags overflow.
//
// Ports:
//   clk_i        in   1      clock, all state on the rising edge
//   rst_ni       in   1      asynchronous active-low reset
//   prod_i       in   N_OUT  signed product term
//   prod_valid_i in   1      prod_i / last_i valid
//   last_i       in   1      current term is the last of the vector
//   prod_ready_o out  1      block accepts a term
//   acc_o        out  ACC_W  signed accumulated sum
//   acc_valid_o  out  1      acc_o / cnt_o / ovf_o are final
//   acc_ready_i  in   1      downstream consumes the result
//   cnt_o        out  CNT_W  number of terms accumulated
//   ovf_o        out  1      sticky signed-overflow flag for this vector
// -----------------------------------------------------------------------------
module mac_accumulator #(
   parameter int N_OUT     = 6,
   parameter int ACC_W     = 12,
   parameter int CNT_W     = 8,
   parameter int MAX_TERMS = 255
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_OUT-1:0] prod_i,
   input  logic             prod_valid_i,
   input  logic             last_i,
   output logic             prod_ready_o,
   output logic [ACC_W-1:0] acc_o,
   output logic             acc_valid_o,
   input  logic             acc_ready_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic signed [ACC_W-1:0] acc_r;
   logic signed [ACC_W-1:0] acc_nxt_s;
   logic        [CNT_W-1:0] cnt_r;
   logic        [CNT_W-1:0] cnt_nxt_s;
   logic                    ovf_r;
   logic                    ovf_nxt_s;

   logic signed [ACC_W-1:0] prod_ext_s;
   logic signed [ACC_W-1:0] sum_raw_s;
   logic signed [ACC_W-1:0] sum_s;
   logic                    sum_ovf_s;
   logic        [CNT_W-1:0] cnt_inc_s;
   logic                    term_hs_s;
   logic                    res_hs_s;
   logic                    max_is_one_s;

   // Signed add overflows when both operands share a sign the result lacks.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   // Handshakes, operand extension and the candidate next sum.
   always_comb begin
      prod_ready_o = (state_r == ACCUM) ? 1'b1 : acc_ready_i;
      acc_valid_o  = (state_r == HOLD);
      term_hs_s    = prod_valid_i && prod_ready_o;
      res_hs_s     = acc_valid_o && acc_ready_i;
      prod_ext_s   = ACC_W'($signed(prod_i));
      sum_raw_s    = acc_r + prod_ext_s;
      sum_ovf_s    = add_ovf(acc_r[ACC_W-1], prod_ext_s[ACC_W-1],
                             sum_raw_s[ACC_W-1]);
      cnt_inc_s    = cnt_r + CNT_W'(1);
      max_is_one_s = (CNT_W'(MAX_TERMS) == CNT_W'(1));
`ifdef ACC_SAT_EN
      // Clamp towards the sign shared by both operands.
      if (sum_ovf_s) begin
         sum_s = acc_r[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         sum_s = sum_raw_s;
      end
`else
      sum_s = sum_raw_s;
`endif
   end

   // Next-state and next-datapath logic of the ACCUM/HOLD controller.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      cnt_nxt_s   = cnt_r;
      ovf_nxt_s   = ovf_r;
      case (state_r)
         ACCUM: begin
            if (term_hs_s) begin
               acc_nxt_s = sum_s;
               cnt_nxt_s = cnt_inc_s;
               ovf_nxt_s = ovf_r | sum_ovf_s;
               if (last_i || (cnt_inc_s == CNT_W'(MAX_TERMS))) begin
                  state_nxt_s = HOLD;
               end else begin
                  state_nxt_s = ACCUM;
               end
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         HOLD: begin
            if (res_hs_s) begin
               if (term_hs_s) begin
                  // Result leaves while the next vector's first term arrives.
                  acc_nxt_s = prod_ext_s;
                  cnt_nxt_s = CNT_W'(1);
                  ovf_nxt_s = 1'b0;
                  if (last_i || max_is_one_s) begin
                     state_nxt_s = HOLD;
                  end else begin
                     state_nxt_s = ACCUM;
                  end
               end else begin
                  acc_nxt_s   = {ACC_W{1'b0}};
                  cnt_nxt_s   = {CNT_W{1'b0}};
                  ovf_nxt_s   = 1'b0;
                  state_nxt_s = ACCUM;
               end
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            state_nxt_s = ACCUM;
            acc_nxt_s   = {ACC_W{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial vector.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ACCUM;
         acc_r   <= {ACC_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         ovf_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         acc_r   <= acc_nxt_s;
         cnt_r   <= cnt_nxt_s;
         ovf_r   <= ovf_nxt_s;
      end
   end

   assign acc_o = acc_r;
   assign cnt_o = cnt_r;
   assign ovf_o = ovf_r;

endmodule
